// File: rtl/nfc_status_poll_pkg.sv
// Shared constants for the NAND status-poll block: status-register bit
// positions and the command-type bit meanings understood by phy_status.
package nfc_status_poll_pkg;

  // Bit positions inside the NAND status register.
  typedef enum int unsigned {
    SR_FAIL = 0,
    SR_ARDY = 5,
    SR_RDY  = 6
  } sr_bit_e;

  // Bit meanings of the 3-bit command type handed to phy_status.
  typedef enum int unsigned {
    CMD_BIT_ENH     = 0,
    CMD_BIT_TRAIL00 = 1
  } cmd_bit_e;

  // Builds the phy_status command type from the enhanced/trailing-00h flags.
  function automatic logic [2:0] cmdType(input logic enh, input logic trail00);
    logic [2:0] t;
    t = 3'b000;
    t[CMD_BIT_ENH]     = enh;
    t[CMD_BIT_TRAIL00] = trail00;
    return t;
  endfunction

endpackage

// File: rtl/nfc_status_poll.sv
// nfc_status_poll: repeatedly issues Read Status (70h) or Read Status
// Enhanced (78h) through phy_status until the LUN reports ready, then
// returns the final status byte to the requester.
// Optional feature macro: NFC_POLL_TIMEOUT_EN enables the MAX_POLLS budget;
// without it the block polls indefinitely and o_done_timeout stays 0.
module nfc_status_poll
  import nfc_status_poll_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [15:0] i_req_id,
  input  logic [23:0] i_req_addr,
  input  logic        i_req_enh,
  output logic        o_done,
  output logic [15:0] o_done_id,
  output logic [7:0]  o_done_sr,
  output logic        o_done_fail,
  output logic        o_done_timeout,
  output logic [15:0] o_poll_cnt,
  output logic        o_phy_req,
  input  logic        i_phy_ready,
  output logic [15:0] o_phy_cmd_id,
  output logic [23:0] o_phy_addr,
  output logic [2:0]  o_phy_cmd_type,
  input  logic        i_phy_ack,
  input  logic [7:0]  i_phy_sr,
  input  logic [15:0] i_phy_cmd_id
);

  typedef enum logic [6:0] {
    S_IDLE     = 7'b0000001,
    S_ISSUE    = 7'b0000010,
    S_REQ      = 7'b0000100,
    S_WAIT_ACK = 7'b0001000,
    S_EVAL     = 7'b0010000,
    S_GAP      = 7'b0100000,
    S_DONE     = 7'b1000000
  } state_e;

  localparam logic [15:0] PollLimit = 16'(MAX_POLLS);
  localparam bit          NoGap     = (POLL_GAP == 0);
  localparam logic [15:0] GapLast   = NoGap ? 16'd0 : 16'(POLL_GAP - 1);
`ifdef NFC_POLL_TIMEOUT_EN
  localparam bit          TimeoutEn = 1'b1;
`else
  localparam bit          TimeoutEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] id_q;
  logic [23:0] addr_q;
  logic        enh_q;
  logic [15:0] pollCnt_q;
  logic [15:0] gapCnt_q;
  logic [7:0]  sr_q;
  logic        timeout_q;

  logic accept;
  logic ackHit;
  logic rdy;
  logic budgetHit;

  assign accept    = i_req_valid && (state_q == S_IDLE);
  assign ackHit    = (state_q == S_WAIT_ACK) && i_phy_ack && (i_phy_cmd_id == id_q);
  assign rdy       = sr_q[SR_RDY];
  assign budgetHit = TimeoutEn && (pollCnt_q == PollLimit);

  // State register; reset drops any in-flight poll back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ready status takes priority over the poll budget.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (accept) state_d = S_ISSUE;
      S_ISSUE:    if (i_phy_ready) state_d = S_REQ;
      S_REQ:      state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (ackHit) state_d = S_EVAL;
      S_EVAL: begin
        if (rdy || budgetHit) state_d = S_DONE;
        else if (NoGap)       state_d = S_ISSUE;
        else                  state_d = S_GAP;
      end
      S_GAP:      if (gapCnt_q == GapLast) state_d = S_ISSUE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Request context, poll/gap counters and captured status byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= 16'd0;
      addr_q    <= 24'd0;
      enh_q     <= 1'b0;
      pollCnt_q <= 16'd0;
      gapCnt_q  <= 16'd0;
      sr_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        id_q      <= i_req_id;
        addr_q    <= i_req_addr;
        enh_q     <= i_req_enh;
        pollCnt_q <= 16'd0;
        timeout_q <= 1'b0;
      end
      if ((state_q == S_REQ) && (pollCnt_q != 16'hFFFF)) pollCnt_q <= pollCnt_q + 16'd1;
      if (ackHit) sr_q <= i_phy_sr;
      if (state_q == S_EVAL) begin
        gapCnt_q  <= 16'd0;
        timeout_q <= !rdy && budgetHit;
      end else if (state_q == S_GAP) begin
        gapCnt_q <= gapCnt_q + 16'd1;
      end
    end
  end

  assign o_req_ready    = (state_q == S_IDLE);
  assign o_phy_req      = (state_q == S_REQ);
  assign o_done         = (state_q == S_DONE);
  assign o_done_id      = id_q;
  assign o_done_sr      = sr_q;
  assign o_done_fail    = sr_q[SR_FAIL];
  assign o_done_timeout = TimeoutEn && timeout_q;
  assign o_poll_cnt     = pollCnt_q;
  assign o_phy_cmd_id   = id_q;
  assign o_phy_addr     = addr_q;
  assign o_phy_cmd_type = cmdType(enh_q, 1'b0);

endmodule

// File: tb/tb_nfc_status_poll.sv
// Self-checking bench for nfc_status_poll: a directed vector table, random
// transactions judged by a status-list reference model, and hand-written
// sequences for timeout, unbounded polling and reset during WAIT_ACK.
module tb_nfc_status_poll;

  localparam int unsigned GAP  = 4;
  localparam int unsigned MAXP = 4;
`ifdef NFC_POLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [15:0] i_req_id = '0;
  logic [23:0] i_req_addr = '0;
  logic        i_req_enh = 1'b0;
  logic        i_phy_ready = 1'b0;
  logic        i_phy_ack = 1'b0;
  logic [7:0]  i_phy_sr = '0;
  logic [15:0] i_phy_cmd_id = '0;
  logic        o_req_ready, o_done, o_done_fail, o_done_timeout, o_phy_req;
  logic [15:0] o_done_id, o_poll_cnt, o_phy_cmd_id;
  logic [7:0]  o_done_sr;
  logic [23:0] o_phy_addr;
  logic [2:0]  o_phy_cmd_type;

  nfc_status_poll #(.POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_id(i_req_id), .i_req_addr(i_req_addr), .i_req_enh(i_req_enh),
    .o_done(o_done), .o_done_id(o_done_id), .o_done_sr(o_done_sr),
    .o_done_fail(o_done_fail), .o_done_timeout(o_done_timeout),
    .o_poll_cnt(o_poll_cnt), .o_phy_req(o_phy_req), .i_phy_ready(i_phy_ready),
    .o_phy_cmd_id(o_phy_cmd_id), .o_phy_addr(o_phy_addr),
    .o_phy_cmd_type(o_phy_cmd_type), .i_phy_ack(i_phy_ack),
    .i_phy_sr(i_phy_sr), .i_phy_cmd_id(i_phy_cmd_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int doneSeen = 0;

  // Counts o_done pulses so stray or missing completions can be detected.
  always @(posedge clk) if (o_done) doneSeen++;

  typedef struct {
    logic [15:0] id;
    logic [23:0] addr;
    logic        enh;
    logic        badAck;
    int          nBusy;
    logic [7:0]  busySr;
    logic [7:0]  finalSr;
    int          expPolls;
    logic [7:0]  expSr;
    logic        expFail;
    logic        expTo;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitPhyReq(output bit found);
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      if (o_phy_req === 1'b1) found = 1'b1;
      else tick();
    end
  endtask

  // Reference model: walk the status list; the first ready byte ends the
  // request, otherwise the poll budget (if enabled) ends it as a timeout.
  function automatic void model(input logic [7:0] srs [$], output int polls,
                                output logic [7:0] sr, output logic to);
    polls = 0;
    sr    = 8'h00;
    to    = 1'b0;
    for (int i = 0; i < srs.size(); i++) begin
      polls = i + 1;
      sr    = srs[i];
      if (sr[6]) return;
      if (TO_EN && polls == int'(MAXP)) begin
        to = 1'b1;
        return;
      end
    end
  endfunction

  task automatic checkHeld(input string tag, input logic [15:0] id, input logic [23:0] addr,
                           input logic enh);
    checkOutput({tag, "_cmd_id"}, o_phy_cmd_id, id);
    checkOutput({tag, "_addr"}, o_phy_addr, addr);
    checkOutput({tag, "_cmd_type"}, o_phy_cmd_type, {2'b00, enh});
  endtask

  // One full request: accept, serve every status read, check the completion.
  task automatic applyStimulus(input logic [15:0] id, input logic [23:0] addr, input logic enh,
                               input logic [7:0] srs [$], input int readyDly, input bit badAck,
                               input int expPolls, input logic [7:0] expSr,
                               input logic expFail, input logic expTo);
    int  d0;
    int  expReq;
    int  ackAt;
    bit  found;
    logic [7:0] sr;
    d0 = doneSeen;
    checkOutput("req_ready_idle", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_id    = id;
    i_req_addr  = addr;
    i_req_enh   = enh;
    i_phy_ready = (readyDly == 0);
    tick();
    i_req_valid = 1'b0;
    i_req_id    = 16'($urandom);
    i_req_addr  = 24'($urandom);
    i_req_enh   = 1'($urandom);
    checkOutput("req_ready_busy", o_req_ready, 0);
    for (int k = 0; k < readyDly; k++) begin
      checkOutput("phy_req_not_ready", o_phy_req, 0);
      tick();
    end
    i_phy_ready = 1'b1;
    expReq = (readyDly == 0) ? cyc + 1 : cyc + 1;
    for (int p = 0; p < expPolls; p++) begin
      waitPhyReq(found);
      checkOutput("phy_req_seen", found, 1);
      if (!found) break;
      checkOutput("phy_req_time", cyc, expReq);
      checkHeld("req", id, addr, enh);
      tick();
      checkOutput("phy_req_pulse", o_phy_req, 0);
      repeat ($urandom_range(0, 2)) tick();
      if (badAck && p == 0) begin
        i_phy_ack    = 1'b1;
        i_phy_cmd_id = (id == 16'hBEEF) ? 16'h0BAD : 16'hBEEF;
        i_phy_sr     = 8'hE0;
        tick();
        i_phy_ack = 1'b0;
        tick();
        tick();
        checkOutput("bad_ack_no_done", o_done, 0);
        checkOutput("bad_ack_poll_cnt", o_poll_cnt, p + 1);
      end
      sr = (p < srs.size()) ? srs[p] : srs[srs.size() - 1];
      i_phy_ack    = 1'b1;
      i_phy_cmd_id = id;
      i_phy_sr     = sr;
      ackAt = cyc;
      tick();
      i_phy_ack = 1'b0;
      i_phy_sr  = 8'($urandom);
      if (p == expPolls - 1) begin
        checkOutput("done_not_early", o_done, 0);
        tick();
        checkOutput("done_pulse", o_done, 1);
        checkOutput("done_id", o_done_id, id);
        checkOutput("done_sr", o_done_sr, expSr);
        checkOutput("done_fail", o_done_fail, expFail);
        checkOutput("done_timeout", o_done_timeout, expTo);
        checkOutput("done_poll_cnt", o_poll_cnt, expPolls);
        checkOutput("done_req_ready", o_req_ready, 0);
        checkHeld("done", id, addr, enh);
        tick();
        checkOutput("done_one_cycle", o_done, 0);
        checkOutput("ready_after_done", o_req_ready, 1);
        checkOutput("poll_cnt_kept", o_poll_cnt, expPolls);
      end else begin
        expReq = ackAt + int'(GAP) + 3;
      end
    end
    checkOutput("done_count", doneSeen - d0, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Without the budget the block keeps polling a permanently busy LUN.
  task automatic pollForever(input int nPolls);
    int d0;
    bit found;
    d0 = doneSeen;
    i_req_valid = 1'b1;
    i_req_id    = 16'h0055;
    i_req_enh   = 1'b0;
    i_phy_ready = 1'b1;
    tick();
    i_req_valid = 1'b0;
    for (int p = 0; p < nPolls; p++) begin
      waitPhyReq(found);
      checkOutput("busy_req_seen", found, 1);
      if (!found) break;
      tick();
      i_phy_ack    = 1'b1;
      i_phy_cmd_id = 16'h0055;
      i_phy_sr     = 8'h80;
      tick();
      i_phy_ack = 1'b0;
    end
    tick();
    checkOutput("busy_poll_cnt", o_poll_cnt, nPolls);
    checkOutput("busy_no_done", doneSeen - d0, 0);
    checkOutput("busy_not_ready", o_req_ready, 0);
    doReset();
  endtask

  // Reset while waiting for the ack; a late ack must not complete anything.
  task automatic resetMidWait();
    int d0;
    bit found;
    i_req_valid = 1'b1;
    i_req_id    = 16'h0011;
    i_req_addr  = 24'hABCDEF;
    i_req_enh   = 1'b1;
    i_phy_ready = 1'b1;
    tick();
    i_req_valid = 1'b0;
    waitPhyReq(found);
    checkOutput("rst_req_seen", found, 1);
    tick();
    rst = 1'b1;
    #1;
    d0 = doneSeen;
    checkOutput("rst_req_ready", o_req_ready, 1);
    checkOutput("rst_phy_req", o_phy_req, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_poll_cnt", o_poll_cnt, 0);
    checkOutput("rst_cmd_id", o_phy_cmd_id, 0);
    checkOutput("rst_addr", o_phy_addr, 0);
    checkOutput("rst_cmd_type", o_phy_cmd_type, 0);
    checkOutput("rst_done_id", o_done_id, 0);
    tick();
    rst = 1'b0;
    i_phy_ack    = 1'b1;
    i_phy_cmd_id = 16'h0011;
    i_phy_sr     = 8'hE0;
    tick();
    i_phy_ack = 1'b0;
    repeat (5) tick();
    checkOutput("stale_ack_no_done", doneSeen - d0, 0);
    checkOutput("stale_ack_req_ready", o_req_ready, 1);
    checkOutput("stale_ack_poll_cnt", o_poll_cnt, 0);
  endtask

  // Bounds the whole run even if a wait somewhere goes wrong.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] srs [$];
    int         ePolls;
    logic [7:0] eSr;
    logic       eTo;

    tick();
    checkOutput("reset_req_ready", o_req_ready, 1);
    checkOutput("reset_phy_req", o_phy_req, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_done_fail", o_done_fail, 0);
    checkOutput("reset_done_timeout", o_done_timeout, 0);
    checkOutput("reset_done_sr", o_done_sr, 0);
    checkOutput("reset_poll_cnt", o_poll_cnt, 0);
    checkOutput("reset_cmd_type", o_phy_cmd_type, 0);
    tick();
    rst = 1'b0;
    tick();

    vecs[0] = '{16'h0011, 24'h000000, 1'b0, 1'b1, 0, 8'h00, 8'hE0, 1, 8'hE0, 1'b0, 1'b0};
    vecs[1] = '{16'h0022, 24'h000100, 1'b0, 1'b0, 3, 8'h80, 8'hE1, 4, 8'hE1, 1'b1, 1'b0};
    vecs[2] = '{16'h0033, 24'h012345, 1'b1, 1'b0, 2, 8'h80, 8'hC0, 3, 8'hC0, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1, 8'h81, 8'h40, 2, 8'h40, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      srs = {};
      for (int b = 0; b < vecs[i].nBusy; b++) srs.push_back(vecs[i].busySr);
      srs.push_back(vecs[i].finalSr);
      applyStimulus(vecs[i].id, vecs[i].addr, vecs[i].enh, srs, i % 3, vecs[i].badAck,
                    vecs[i].expPolls, vecs[i].expSr, vecs[i].expFail, vecs[i].expTo);
    end

    for (int r = 0; r < 16; r++) begin
      srs = {};
      repeat ($urandom_range(0, 5)) srs.push_back(8'($urandom) & 8'hBF);
      srs.push_back(8'($urandom) | 8'h40);
      model(srs, ePolls, eSr, eTo);
      applyStimulus(16'($urandom), 24'($urandom), 1'($urandom), srs, $urandom_range(0, 2),
                    1'($urandom), ePolls, eSr, eSr[0], eTo);
    end

    if (TO_EN) begin
      srs = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      applyStimulus(16'h0044, 24'h000444, 1'b0, srs, 0, 1'b0, int'(MAXP), 8'h80, 1'b0, 1'b1);
    end else begin
      pollForever(10);
    end

    resetMidWait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
